// File: rtl/ahb2_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ahb2_bus_arbiter
//
// Purpose:
//   Shares a single AHB2 master-side bus between NUM_MST masters. Requests
//   are arbitrated round-robin starting after the most recently granted
//   master. Fixed-length bursts (INCR4/8/16, WRAP4/8/16) are protected, so
//   the bus is never handed over in the middle of one. The block also
//   publishes the address-phase owner and the data-phase owner. The address
//   and data multiplexers use these indices to steer the bus.
//
// Parameters:
//   NUM_MST      number of masters (2..16)
//   DEFAULT_MST  master that is granted when nobody requests the bus
//   MW           owner index width, derived from NUM_MST
//
// Ports:
//   hclk       bus clock
//   hreset     synchronous, active-high reset
//   hbusreq    bus request, one bit per master
//   htrans     muxed htrans of the current address-phase owner
//   hburst     muxed hburst of the current address-phase owner
//   hready     bus hready; a transfer is accepted when high at the clock edge
//   hgrant     registered one-hot grant
//   hmaster    registered address-phase owner index
//   hmaster_d  registered data-phase owner index
// -----------------------------------------------------------------------------
module ahb2_bus_arbiter #(
    parameter  int NUM_MST     = 4,
    parameter  int DEFAULT_MST = 0,
    localparam int MW          = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic [MW-1:0]      hmaster_d
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [MW-1:0]      DEFAULT_IDX   = MW'(DEFAULT_MST);
    localparam logic [NUM_MST-1:0] DEFAULT_GRANT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEFAULT_MST;

    state_t               state_q,    state_d;
    logic [3:0]           beat_cnt_q, beat_cnt_d;
    logic [MW-1:0]        last_q,     last_d;
    logic [NUM_MST-1:0]   grant_q,    grant_d;
    logic [MW-1:0]        owner_a_q,  owner_a_d;
    logic [MW-1:0]        owner_d_q,  owner_d_d;

    logic [MW-1:0]        winner;
    logic                 found;
    logic                 fixed_burst;
    logic                 regrant;

    // Beats remaining after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
        logic [3:0] len;
        case (burst)
            3'b010, 3'b011: len = 4'd3;
            3'b100, 3'b101: len = 4'd7;
            3'b110, 3'b111: len = 4'd15;
            default:        len = 4'd0;
        endcase
        return len;
    endfunction

    // SINGLE (000) and undefined-length INCR (001) are the only bursts
    // without a fixed beat count.
    assign fixed_burst = hburst[2] | hburst[1];

    // Round-robin search. It starts just after the last granted master, so
    // the current owner is checked last and therefore has lowest priority.
    always_comb begin
        winner = DEFAULT_IDX;
        found  = 1'b0;
        for (int i = 1; i <= NUM_MST; i++) begin
            logic [MW-1:0] cand_idx;
            cand_idx = MW'((int'(last_q) + i) % NUM_MST);
            if (!found && hbusreq[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    // Burst tracker. An accepted NONSEQ with a fixed-length hburst locks the
    // grant. Each accepted SEQ consumes one beat. BUSY only stalls the burst.
    // An accepted IDLE or NONSEQ inside a burst means the owner abandoned it
    // (for example after an ERROR response). A new fixed burst re-locks the
    // grant; anything else releases it.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (hready) begin
            case (state_q)
                ARB: begin
                    if (htrans == HTRANS_NONSEQ && fixed_burst) begin
                        state_d    = BURST;
                        beat_cnt_d = burst_len_m1(hburst);
                    end
                end
                BURST: begin
                    case (htrans)
                        HTRANS_SEQ: begin
                            if (beat_cnt_q <= 4'd1) begin
                                beat_cnt_d = 4'd0;
                                state_d    = ARB;
                            end else begin
                                beat_cnt_d = beat_cnt_q - 4'd1;
                            end
                        end
                        HTRANS_BUSY: begin
                            beat_cnt_d = beat_cnt_q;
                        end
                        HTRANS_NONSEQ: begin
                            if (fixed_burst) begin
                                beat_cnt_d = burst_len_m1(hburst);
                            end else begin
                                beat_cnt_d = 4'd0;
                                state_d    = ARB;
                            end
                        end
                        default: begin
                            beat_cnt_d = 4'd0;
                            state_d    = ARB;
                        end
                    endcase
                end
                default: begin
                    state_d    = ARB;
                    beat_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // The grant moves only on an accepting edge that leaves the tracker in
    // ARB. As a result, the edge that accepts the final burst beat can
    // already hand the bus over. last_q always mirrors the index of grant_q,
    // so it doubles as the address owner for the next cycle.
    always_comb begin
        regrant   = hready && (state_d == ARB);
        grant_d   = grant_q;
        last_d    = last_q;
        owner_a_d = owner_a_q;
        owner_d_d = owner_d_q;
        if (regrant) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            last_d          = winner;
        end
        if (hready) begin
            owner_a_d = last_q;
            owner_d_d = owner_a_q;
        end
    end

    // State registers. Reset drops any in-flight burst and returns the bus
    // to the default master.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ARB;
            beat_cnt_q <= 4'd0;
            last_q     <= DEFAULT_IDX;
            grant_q    <= DEFAULT_GRANT;
            owner_a_q  <= DEFAULT_IDX;
            owner_d_q  <= DEFAULT_IDX;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            owner_a_q  <= owner_a_d;
            owner_d_q  <= owner_d_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = owner_a_q;
    assign hmaster_d = owner_d_q;

endmodule
